muxpga_job_sequencer: RTL

//  Drives the 8-bit control port of the muxpga fabric (cmd/nibble/reset) for one job at a time.
//  A job is: clear the fabric, load the config bitstream, run the cells, capture the output byte.
//  The bitstream arrives over a valid/ready nibble stream. The top level packs
//  {fpga_cmd, fpga_nibble, fpga_rst, clk} into the fabric io_in.

---
 rtl/muxpga_job_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/muxpga_job_sequencer.sv
// Job sequencer for the muxpga fabric control port: clear, load the config
// bitstream from a valid/ready nibble stream, run the cells, capture one output byte.
module muxpga_job_sequencer #(
    parameter int NIBBLES = 24,
    parameter int RUN_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic [3:0]       data_nibble,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_nibble,
    output logic             cfg_ready,
    output logic [1:0]       fpga_cmd,
    output logic [3:0]       fpga_nibble,
    output logic             fpga_rst,
    input  logic [7:0]       fpga_out,
    output logic [7:0]       result,
    output logic             result_valid,
    output logic             busy
);

    localparam int CNT_W = $clog2(NIBBLES + 1);
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    localparam logic [1:0] CMD_SHIFT = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_HOLD  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_RUN,
        S_CAPT,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] nib_cnt;
    logic [RUN_W-1:0] run_cnt;

    // NOTE: every output is a flop written with <=; the state seen in cycle t
    // decides what the fabric sees in cycle t+1, so there is no combinational path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            nib_cnt      <= '0;
            run_cnt      <= '0;
            fpga_cmd     <= CMD_HOLD;
            fpga_nibble  <= '0;
            fpga_rst     <= 1'b1;
            cfg_ready    <= 1'b0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    fpga_cmd <= CMD_HOLD;
                    fpga_rst <= 1'b0;
                    if (start) begin
                        run_cnt <= run_cycles;
                        nib_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    fpga_cmd  <= CMD_HOLD;
                    fpga_rst  <= 1'b1;
                    cfg_ready <= 1'b1;
                    state     <= S_LOAD;
                end
                S_LOAD: begin
                    fpga_rst <= 1'b0;
                    // The chain only shifts on an accepted nibble; idle cycles hold.
                    if (cfg_valid) begin
                        fpga_cmd    <= CMD_SHIFT;
                        fpga_nibble <= cfg_nibble;
                        nib_cnt     <= nib_cnt + 1'b1;
                        if (nib_cnt == LAST_NIB) begin
                            cfg_ready <= 1'b0;
                            state     <= S_RUN;
                        end
                    end else begin
                        fpga_cmd <= CMD_HOLD;
                    end
                end
                S_RUN: begin
                    if (run_cnt != '0) begin
                        fpga_cmd    <= CMD_RUN;
                        fpga_nibble <= data_nibble;
                        run_cnt     <= run_cnt - 1'b1;
                        if (run_cnt == RUN_W'(1)) state <= S_CAPT;
                    end else begin
                        fpga_cmd <= CMD_HOLD;
                        state    <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    // A shift makes io_out show the last row; it also consumes the config.
                    fpga_cmd    <= CMD_SHIFT;
                    fpga_nibble <= data_nibble;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    fpga_cmd     <= CMD_HOLD;
                    result       <= fpga_out;
                    result_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= S_IDLE;
                end
                default: begin
                    fpga_cmd  <= CMD_HOLD;
                    cfg_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
